// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter
//   Shares one FIFO push port between NREQ producers. A round-robin arbiter
//   grants at most one requester per cycle. The winner's data is registered
//   onto fifo_push/fifo_datain, which drive the FIFO directly. A credit
//   counter tracks free FIFO slots, so a push is never issued into a full FIFO.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset (shared with the FIFO)
//   req             per-requester push request, held until granted
//   data            requester i data in bits [i*BUSW +: BUSW]
//   gnt             one-hot grant (combinational); transfer on posedge when req&gnt
//   fifo_push       registered push strobe to the FIFO
//   fifo_datain     registered push data to the FIFO
//   fifo_full       FIFO full flag; only used to raise err[0]
//   fifo_pull       FIFO pull strobe (driven by the consumer)
//   fifo_empty      FIFO empty flag
//   credits         number of free FIFO slots
//   err             sticky flags: [0] push while full, [1] credit overflow
//
// Optional feature (macro FIFO_ARB_STATS_EN)
//   Adds per-requester saturating 16-bit grant counters, read through
//   stat_sel (input) / stat_cnt (output, combinational).

module fifo_push_arbiter #(
   parameter int NREQ    = 4,
   parameter int BUSW    = 32,
   parameter int ENTRIES = 32,
   localparam int PW     = $clog2(NREQ),
   localparam int CW     = $clog2(ENTRIES + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*BUSW-1:0] data,
   output logic [NREQ-1:0]      gnt,
   output logic                 fifo_push,
   output logic [BUSW-1:0]      fifo_datain,
   input  logic                 fifo_full,
   input  logic                 fifo_pull,
   input  logic                 fifo_empty,
   output logic [CW-1:0]        credits,
   output logic [1:0]           err
`ifdef FIFO_ARB_STATS_EN
   ,
   input  logic [PW-1:0]        stat_sel,
   output logic [15:0]          stat_cnt
`endif
);

   logic [PW-1:0]   ptr_q,    ptr_d;
   logic [CW-1:0]   credits_q, credits_d;
   logic            push_q,   push_d;
   logic [BUSW-1:0] datain_q, datain_d;
   logic [1:0]      err_q,    err_d;

   logic            gnt_any;
   logic [PW-1:0]   gnt_idx;
   logic            pop;
   int              idx;

   // Round-robin search starting at ptr. Grants are suppressed while reset
   // is asserted and whenever no downstream credit is left.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      idx     = 0;
      if (!rst && credits_q != '0) begin
         for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!gnt_any && req[idx]) begin
               gnt_any  = 1'b1;
               gnt_idx  = PW'(idx);
               gnt[idx] = 1'b1;
            end
         end
      end
   end

   // A pop only frees a slot if the FIFO actually had something to give.
   assign pop = fifo_pull & ~fifo_empty;

   always_comb begin
      ptr_d     = ptr_q;
      push_d    = gnt_any;
      datain_d  = datain_q;
      credits_d = credits_q;
      err_d     = err_q;

      if (gnt_any) begin
         datain_d = data[int'(gnt_idx)*BUSW +: BUSW];
         ptr_d    = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end

      // Simultaneous grant and pop cancel out.
      unique case ({gnt_any, pop})
         2'b10: credits_d = credits_q - 1'b1;
         2'b01: begin
            if (credits_q == CW'(ENTRIES))
               err_d[1] = 1'b1;      // more pops than pushes: hold and flag
            else
               credits_d = credits_q + 1'b1;
         end
         default: credits_d = credits_q;
      endcase

      if (push_q && fifo_full)
         err_d[0] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q     <= '0;
         credits_q <= CW'(ENTRIES);
         push_q    <= 1'b0;
         datain_q  <= '0;
         err_q     <= '0;
      end else begin
         ptr_q     <= ptr_d;
         credits_q <= credits_d;
         push_q    <= push_d;
         datain_q  <= datain_d;
         err_q     <= err_d;
      end
   end

   assign fifo_push   = push_q;
   assign fifo_datain = datain_q;
   assign credits     = credits_q;
   assign err         = err_q;

`ifdef FIFO_ARB_STATS_EN
   logic [15:0] cnt_q [NREQ];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++)
            if (gnt[i] && cnt_q[i] != 16'hFFFF)
               cnt_q[i] <= cnt_q[i] + 16'd1;
      end
   end

   // Selectors beyond NREQ-1 (non power-of-two NREQ) read as zero.
   always_comb begin
      stat_cnt = '0;
      if (int'(stat_sel) < NREQ)
         stat_cnt = cnt_q[stat_sel];
   end
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
module tb_fifo_push_arbiter;

   localparam int NREQ    = 4;
   localparam int BUSW    = 32;
   localparam int ENTRIES = 32;
   localparam int PW      = $clog2(NREQ);
   localparam int CW      = $clog2(ENTRIES + 1);

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      req;
   logic [NREQ*BUSW-1:0] data;
   logic [NREQ-1:0]      gnt;
   logic                 fifo_push;
   logic [BUSW-1:0]      fifo_datain;
   logic                 fifo_full;
   logic                 fifo_pull;
   logic                 fifo_empty;
   logic [CW-1:0]        credits;
   logic [1:0]           err;
   logic [PW-1:0]        stat_sel;
   logic [15:0]          stat_cnt;

   always #5 clk = ~clk;

   fifo_push_arbiter #(.NREQ(NREQ), .BUSW(BUSW), .ENTRIES(ENTRIES)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .data        (data),
      .gnt         (gnt),
      .fifo_push   (fifo_push),
      .fifo_datain (fifo_datain),
      .fifo_full   (fifo_full),
      .fifo_pull   (fifo_pull),
      .fifo_empty  (fifo_empty),
      .credits     (credits),
      .err         (err)
`ifdef FIFO_ARB_STATS_EN
      ,
      .stat_sel    (stat_sel),
      .stat_cnt    (stat_cnt)
`endif
   );

`ifndef FIFO_ARB_STATS_EN
   assign stat_cnt = 16'h0;
`endif

   // Occupancy model of the downstream FIFO, with overrides for error tests.
   int   model_cnt;
   logic force_full;
   logic force_nempty;

   assign fifo_full  = (model_cnt == ENTRIES) || force_full;
   assign fifo_empty = (model_cnt == 0) && !force_nempty;

   always @(posedge clk or posedge rst) begin
      if (rst)
         model_cnt <= 0;
      else
         model_cnt <= model_cnt + (fifo_push ? 1 : 0)
                      - ((fifo_pull && model_cnt > 0) ? 1 : 0);
   end

   int total = 0;
   int bad   = 0;
   int push_seen = 0;
   logic [BUSW-1:0] sbq [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: each observed grant queues the winner's data; each push
   // pops the queue and compares. Reset drops any in-flight push.
   task automatic monitor();
      forever begin
         @(negedge clk);
         if (rst) begin
            sbq.delete();
         end else begin
            if (fifo_push) begin
               push_seen++;
               if (sbq.size() == 0) chk("sb_unexpected_push", 64'd1, 64'd0);
               else                 chk("sb_datain", 64'(fifo_datain), 64'(sbq.pop_front()));
            end
            chk("gnt_legal", 64'(((gnt & ~req) == '0) && $onehot0(gnt)), 64'd1);
            for (int i = 0; i < NREQ; i++)
               if (gnt[i]) sbq.push_back(data[i*BUSW +: BUSW]);
         end
      end
   endtask

   task automatic rand_data();
      for (int i = 0; i < NREQ; i++) data[i*BUSW +: BUSW] = $urandom;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      fifo_pull = 1'b0;
      force_full = 1'b0;
      force_nempty = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   typedef struct {
      logic [NREQ-1:0] req;
      logic [NREQ-1:0] gnt;
      int              cred;
   } vec_t;

   vec_t tbl [14];

   initial begin
      // Requests, expected grant, expected credits before that edge (no pulls).
      tbl[0]  = '{4'hF,    4'b0001, 32};
      tbl[1]  = '{4'hF,    4'b0010, 31};
      tbl[2]  = '{4'hF,    4'b0100, 30};
      tbl[3]  = '{4'hF,    4'b1000, 29};
      tbl[4]  = '{4'hF,    4'b0001, 28};
      tbl[5]  = '{4'hF,    4'b0010, 27};
      tbl[6]  = '{4'hF,    4'b0100, 26};
      tbl[7]  = '{4'hF,    4'b1000, 25};
      tbl[8]  = '{4'b0101, 4'b0001, 24};
      tbl[9]  = '{4'b0101, 4'b0100, 23};
      tbl[10] = '{4'b0011, 4'b0001, 22};
      tbl[11] = '{4'b1000, 4'b1000, 21};
      tbl[12] = '{4'b0000, 4'b0000, 20};
      tbl[13] = '{4'b0110, 4'b0010, 20};

      rst = 1'b1;
      req = 4'hF;
      fifo_pull = 1'b0;
      force_full = 1'b0;
      force_nempty = 1'b0;
      stat_sel = '0;
      rand_data();
      fork monitor(); join_none

      // Reset state with all requests pending.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt", 64'(gnt), 64'd0);
      chk("rst_push", 64'(fifo_push), 64'd0);
      chk("rst_credits", 64'(credits), 64'd32);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_datain", 64'(fifo_datain), 64'd0);
      rst = 1'b0;
      #1 chk("post_rst_gnt", 64'(gnt), 64'b0001);

      // Round robin and masked request patterns.
      for (int r = 0; r < 14; r++) begin
         req = tbl[r].req;
         rand_data();
         #1;
         chk($sformatf("tbl%0d_gnt", r), 64'(gnt), 64'(tbl[r].gnt));
         chk($sformatf("tbl%0d_credits", r), 64'(credits), 64'(tbl[r].cred));
         @(posedge clk);
         #1;
      end
      req = '0;
      chk("tbl_end_credits", 64'(credits), 64'd19);
      repeat (2) @(posedge clk);
      #1 chk("tbl_drain", 64'(sbq.size()), 64'd0);

      // Async reset drops an in-flight push.
      req = 4'b0001;
      @(posedge clk);
      #1 req = '0;
      chk("inflight_push", 64'(fifo_push), 64'd1);
      rst = 1'b1;
      #1;
      chk("async_rst_push", 64'(fifo_push), 64'd0);
      chk("async_rst_credits", 64'(credits), 64'd32);
      chk("async_rst_gnt", 64'(gnt), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Fill: one requester, no pulls.
      do_reset();
      push_seen = 0;
      req = 4'b0100;
      rand_data();
      repeat (40) @(posedge clk);
      #1;
      chk("fill_pushes", 64'(push_seen), 64'd32);
      chk("fill_credits", 64'(credits), 64'd0);
      chk("fill_gnt", 64'(gnt), 64'd0);
      chk("fill_err", 64'(err), 64'd0);
      chk("fill_fifo_full", 64'(fifo_full), 64'd1);

      // Credit return at zero, then pop and grant in the same cycle.
      fifo_pull = 1'b1;
      @(posedge clk);
      #1 fifo_pull = 1'b0;
      chk("pop0_credits", 64'(credits), 64'd1);
      chk("pop0_gnt", 64'(gnt), 64'b0100);
      @(posedge clk);
      #1 chk("regrant_credits", 64'(credits), 64'd0);
      fifo_pull = 1'b1;
      @(posedge clk);
      #1 chk("pop1_credits", 64'(credits), 64'd1);
      chk("pop1_gnt", 64'(gnt), 64'b0100);
      @(posedge clk);
      #1 chk("popgrant_credits", 64'(credits), 64'd1);
      fifo_pull = 1'b0;
      @(posedge clk);
      #1 chk("final_fill_credits", 64'(credits), 64'd0);
      chk("simul_err", 64'(err), 64'd0);
      req = '0;

      // Push while full flag forced.
      do_reset();
      req = 4'b0001;
      @(posedge clk);
      #1 req = '0;
      force_full = 1'b1;
      @(posedge clk);
      #1 chk("err0_set", 64'(err), 64'b01);
      force_full = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("err0_sticky", 64'(err), 64'b01);

      // Pop with all credits already returned.
      do_reset();
      chk("err_cleared", 64'(err), 64'd0);
      force_nempty = 1'b1;
      fifo_pull = 1'b1;
      @(posedge clk);
      #1;
      chk("err1_set", 64'(err), 64'b10);
      chk("err1_credits", 64'(credits), 64'd32);
      fifo_pull = 1'b0;
      force_nempty = 1'b0;
      @(posedge clk);
      #1 chk("err1_sticky", 64'(err), 64'b10);

`ifdef FIFO_ARB_STATS_EN
      do_reset();
      fifo_pull = 1'b1;
      req = 4'b0010;
      rand_data();
      repeat (5) @(posedge clk);
      #1 req = '0;
      stat_sel = PW'(1);
      #1 chk("stat_req1", 64'(stat_cnt), 64'd5);
      req = 4'b0001;
      repeat (70000) @(posedge clk);
      #1 req = '0;
      stat_sel = PW'(0);
      #1 chk("stat_req0_sat", 64'(stat_cnt), 64'hFFFF);
      stat_sel = PW'(1);
      #1 chk("stat_req1_hold", 64'(stat_cnt), 64'd5);
      fifo_pull = 1'b0;
`endif

      req = '0;
      repeat (3) @(posedge clk);
      #1 chk("final_drain", 64'(sbq.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
